// File: rtl/ec_pkg.sv
// Shared types and sizing helpers for the encode sequencer slice.
package ec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    CALC,
    DONE
  } ec_state_e;

  // Width needed to hold the value m_max itself.
  function automatic int m_w(input int m_max);
    return $clog2(m_max + 1);
  endfunction

  // Width of a row index 0 .. m_max-1 (kept at least 1 bit wide).
  function automatic int row_w(input int m_max);
    return (m_max > 1) ? $clog2(m_max) : 1;
  endfunction

endpackage

// File: rtl/encode_seq_cntl_if.sv
// FIFO, bitmatrix memory and engine strobes driven by the encode sequencer.
interface encode_seq_cntl_if
  import ec_pkg::*;
#(
  parameter int M_MAX = 128,
  localparam int ROW_W = row_w(M_MAX)
);

  logic             inbuf_fifo_empty;
  logic             inbuf_fifo_rd_rq;
  logic             outbuf_fifo_afull;
  logic             outbuf_fifo_wr_rq;
  logic             bm_mem_rd_en;
  logic [ROW_W-1:0] bm_mem_rd_addr;
  logic             eng_calc_en;
  logic             eng_line_load;

  modport master (
    input  inbuf_fifo_empty, outbuf_fifo_afull,
    output inbuf_fifo_rd_rq, outbuf_fifo_wr_rq, bm_mem_rd_en,
           bm_mem_rd_addr, eng_calc_en, eng_line_load
  );

  modport slave (
    output inbuf_fifo_empty, outbuf_fifo_afull,
    input  inbuf_fifo_rd_rq, outbuf_fifo_wr_rq, bm_mem_rd_en,
           bm_mem_rd_addr, eng_calc_en, eng_line_load
  );

endinterface

// File: rtl/encode_seq_cntl.sv
// Job sequencer: per data line, pop one input line, load it into the engine,
// then issue M_eff bitmatrix row reads / parity calcs, throttled by output FIFO.
module encode_seq_cntl
  import ec_pkg::*;
#(
  parameter int M_MAX      = 128,
  parameter int M_MIN      = 2,
  parameter int LINE_CNT_W = 16,
  localparam int M_W       = m_w(M_MAX),
  localparam int ROW_W     = row_w(M_MAX)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  eng_rstn,
  input  logic                  cntrl_start,
  input  logic [M_W-1:0]        MReg,
  input  logic [LINE_CNT_W-1:0] line_cnt_reg,
  encode_seq_cntl_if.master     bus,
  output logic                  seq_busy,
  output logic                  seq_done
);

  ec_state_e             state;
  logic [ROW_W-1:0]      row;
  logic [LINE_CNT_W-1:0] lines_left;
  logic [M_W-1:0]        m_eff;

  function automatic logic [M_W-1:0] clamp_m(input logic [M_W-1:0] m);
    if (m < M_W'(M_MIN))      return M_W'(M_MIN);
    else if (m > M_W'(M_MAX)) return M_W'(M_MAX);
    else                      return m;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                 <= IDLE;
      row                   <= '0;
      lines_left            <= '0;
      m_eff                 <= '0;
      bus.inbuf_fifo_rd_rq  <= 1'b0;
      bus.eng_line_load     <= 1'b0;
      bus.bm_mem_rd_en      <= 1'b0;
      bus.bm_mem_rd_addr    <= '0;
      bus.eng_calc_en       <= 1'b0;
      bus.outbuf_fifo_wr_rq <= 1'b0;
      seq_busy              <= 1'b0;
      seq_done              <= 1'b0;
    end else if (!eng_rstn) begin
      state                 <= IDLE;
      row                   <= '0;
      lines_left            <= '0;
      m_eff                 <= '0;
      bus.inbuf_fifo_rd_rq  <= 1'b0;
      bus.eng_line_load     <= 1'b0;
      bus.bm_mem_rd_en      <= 1'b0;
      bus.bm_mem_rd_addr    <= '0;
      bus.eng_calc_en       <= 1'b0;
      bus.outbuf_fifo_wr_rq <= 1'b0;
      seq_busy              <= 1'b0;
      seq_done              <= 1'b0;
    end else begin
      bus.inbuf_fifo_rd_rq  <= 1'b0;
      bus.eng_line_load     <= 1'b0;
      bus.bm_mem_rd_en      <= 1'b0;
      bus.eng_calc_en       <= 1'b0;
      seq_done              <= 1'b0;
      // The parity row leaves the engine one cycle after its calc strobe.
      bus.outbuf_fifo_wr_rq <= bus.eng_calc_en;

      unique case (state)
        IDLE: begin
          if (cntrl_start) begin
            m_eff      <= clamp_m(MReg);
            lines_left <= line_cnt_reg;
            seq_busy   <= 1'b1;
            state      <= (line_cnt_reg == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          if (!bus.inbuf_fifo_empty) begin
            bus.inbuf_fifo_rd_rq <= 1'b1;
            state                <= LOAD;
          end
        end
        LOAD: begin
          bus.eng_line_load <= 1'b1;
          row               <= '0;
          state             <= CALC;
        end
        CALC: begin
          // Address tracks the pending row even while stalled.
          bus.bm_mem_rd_addr <= row;
          if (!bus.outbuf_fifo_afull) begin
            bus.bm_mem_rd_en <= 1'b1;
            bus.eng_calc_en  <= 1'b1;
            row              <= row + ROW_W'(1);
            if (M_W'(row) == m_eff - M_W'(1)) begin
              lines_left <= lines_left - LINE_CNT_W'(1);
              state      <= (lines_left == LINE_CNT_W'(1)) ? DONE : FETCH;
            end
          end
        end
        DONE: begin
          // Also wait out a calc strobe still in flight so done never precedes the last push.
          if (!bus.outbuf_fifo_wr_rq && !bus.eng_calc_en) begin
            seq_done <= 1'b1;
            seq_busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encode_seq_cntl.sv
// Directed bench for encode_seq_cntl: hand-computed counts, addresses and timing.
module tb_encode_seq_cntl;

  localparam int M_MAX = 128;
  localparam int LCW   = 16;
  localparam int MW    = 8;

  logic           clk = 1'b0;
  logic           rstn, eng_rstn, cntrl_start;
  logic [MW-1:0]  MReg;
  logic [LCW-1:0] line_cnt_reg;
  logic           seq_busy, seq_done;

  encode_seq_cntl_if #(.M_MAX(M_MAX)) bus_if ();

  encode_seq_cntl #(.M_MAX(M_MAX), .M_MIN(2), .LINE_CNT_W(LCW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .eng_rstn     (eng_rstn),
    .cntrl_start  (cntrl_start),
    .MReg         (MReg),
    .line_cnt_reg (line_cnt_reg),
    .bus          (bus_if),
    .seq_busy     (seq_busy),
    .seq_done     (seq_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_rd, n_calc, n_wr, n_done, n_load, n_mem;
  int addr_q[$];

  always @(negedge clk) begin
    if (bus_if.inbuf_fifo_rd_rq)  n_rd++;
    if (bus_if.eng_calc_en) begin
      n_calc++;
      addr_q.push_back(int'(bus_if.bm_mem_rd_addr));
    end
    if (bus_if.outbuf_fifo_wr_rq) n_wr++;
    if (seq_done)                 n_done++;
    if (bus_if.eng_line_load)     n_load++;
    if (bus_if.bm_mem_rd_en)      n_mem++;
  end

  function automatic logic [13:0] all_outs();
    return {bus_if.inbuf_fifo_rd_rq, bus_if.bm_mem_rd_en, bus_if.eng_calc_en,
            bus_if.eng_line_load, bus_if.outbuf_fifo_wr_rq, bus_if.bm_mem_rd_addr,
            seq_busy, seq_done};
  endfunction

  task automatic clr_mon();
    @(posedge clk);
    n_rd = 0; n_calc = 0; n_wr = 0; n_done = 0; n_load = 0; n_mem = 0;
    addr_q.delete();
  endtask

  task automatic run_job(input int m, input int lines, input int budget, output bit timed_out);
    int cyc;
    clr_mon();
    @(negedge clk);
    MReg = MW'(m); line_cnt_reg = LCW'(lines); cntrl_start = 1'b1;
    @(negedge clk);
    cntrl_start = 1'b0;
    cyc = 1;
    while (!seq_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    timed_out = !seq_done;
    #1;
  endtask

  task automatic test_reset();
    bit to;
    rstn = 1'b0; eng_rstn = 1'b1; cntrl_start = 1'b0;
    MReg = 8'd4; line_cnt_reg = 16'd1;
    bus_if.inbuf_fifo_empty = 1'b0; bus_if.outbuf_fifo_afull = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (all_outs() !== 14'h0) begin
      bad++; $display("FAIL reset_outs got=%h want=0", all_outs());
    end
    rstn = 1'b1;
    // Asynchronous reset taken mid-CALC must clear outputs before the next edge.
    @(negedge clk);
    MReg = 8'd4; line_cnt_reg = 16'd3; cntrl_start = 1'b1;
    @(negedge clk);
    cntrl_start = 1'b0;
    for (int i = 0; i < 20 && !bus_if.eng_calc_en; i++) @(negedge clk);
    total++;
    if (bus_if.eng_calc_en !== 1'b1) begin
      bad++; $display("FAIL async_setup calc_en got=%b want=1", bus_if.eng_calc_en);
    end
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    total++;
    if (all_outs() !== 14'h0) begin
      bad++; $display("FAIL async_reset_outs got=%h want=0", all_outs());
    end
    @(negedge clk);
    rstn = 1'b1;
    run_job(2, 1, 100, to);
    total++;
    if (to || n_calc != 2) begin
      bad++; $display("FAIL post_reset_job calc=%0d timeout=%0d want calc=2", n_calc, to);
    end
  endtask

  task automatic test_basic();
    bit to;
    int exp_a[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    bit seq_ok;
    run_job(4, 2, 200, to);
    total++;
    if (to) begin bad++; $display("FAIL basic_timeout seq_done never seen"); end
    total++;
    if (n_rd != 2) begin bad++; $display("FAIL basic_rd_rq got=%0d want=2", n_rd); end
    total++;
    if (n_calc != 8 || n_mem != 8) begin
      bad++; $display("FAIL basic_calc got calc=%0d mem=%0d want 8/8", n_calc, n_mem);
    end
    total++;
    if (n_wr != 8) begin bad++; $display("FAIL basic_wr_rq got=%0d want=8", n_wr); end
    total++;
    if (n_done != 1 || n_load != 2) begin
      bad++; $display("FAIL basic_done_load got done=%0d load=%0d want 1/2", n_done, n_load);
    end
    seq_ok = (addr_q.size() == 8);
    for (int i = 0; i < 8 && seq_ok; i++) if (addr_q[i] != exp_a[i]) seq_ok = 1'b0;
    total++;
    if (!seq_ok) begin
      bad++; $display("FAIL basic_addr_seq got=%p want=0,1,2,3,0,1,2,3", addr_q);
    end
    total++;
    if (seq_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", seq_busy); end
  endtask

  task automatic test_fifo_empty();
    bit to;
    int cyc;
    clr_mon();
    bus_if.inbuf_fifo_empty = 1'b1;
    @(negedge clk);
    MReg = 8'd2; line_cnt_reg = 16'd1; cntrl_start = 1'b1;
    @(negedge clk);
    cntrl_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (bus_if.inbuf_fifo_rd_rq !== 1'b0) begin
        bad++; $display("FAIL empty_hold cyc=%0d rd_rq got=%b want=0", i, bus_if.inbuf_fifo_rd_rq);
      end
    end
    bus_if.inbuf_fifo_empty = 1'b0;
    @(negedge clk);
    total++;
    if (bus_if.inbuf_fifo_rd_rq !== 1'b1) begin
      bad++; $display("FAIL empty_release rd_rq got=%b want=1", bus_if.inbuf_fifo_rd_rq);
    end
    cyc = 0;
    while (!seq_done && cyc < 100) begin @(negedge clk); cyc++; end
    to = !seq_done;
    #1;
    total++;
    if (to || n_rd != 1 || n_calc != 2) begin
      bad++; $display("FAIL empty_job rd=%0d calc=%0d timeout=%0d want 1/2/0", n_rd, n_calc, to);
    end
  endtask

  task automatic test_stall();
    int cyc;
    bit seq_ok;
    clr_mon();
    @(negedge clk);
    MReg = 8'd4; line_cnt_reg = 16'd1; cntrl_start = 1'b1;
    @(negedge clk);
    cntrl_start = 1'b0;
    for (int i = 0; i < 20 && !bus_if.eng_line_load; i++) @(negedge clk);
    @(negedge clk);
    total++;
    if (bus_if.eng_calc_en !== 1'b1 || bus_if.bm_mem_rd_addr !== 7'd0) begin
      bad++; $display("FAIL stall_row0 calc=%b addr=%0d want 1/0", bus_if.eng_calc_en, bus_if.bm_mem_rd_addr);
    end
    @(negedge clk);
    total++;
    if (bus_if.eng_calc_en !== 1'b1 || bus_if.bm_mem_rd_addr !== 7'd1) begin
      bad++; $display("FAIL stall_row1 calc=%b addr=%0d want 1/1", bus_if.eng_calc_en, bus_if.bm_mem_rd_addr);
    end
    bus_if.outbuf_fifo_afull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus_if.eng_calc_en !== 1'b0 || bus_if.bm_mem_rd_en !== 1'b0 || bus_if.bm_mem_rd_addr !== 7'd2) begin
        bad++; $display("FAIL stall_hold cyc=%0d calc=%b rd_en=%b addr=%0d want 0/0/2",
                        i, bus_if.eng_calc_en, bus_if.bm_mem_rd_en, bus_if.bm_mem_rd_addr);
      end
    end
    bus_if.outbuf_fifo_afull = 1'b0;
    @(negedge clk);
    total++;
    if (bus_if.eng_calc_en !== 1'b1 || bus_if.bm_mem_rd_addr !== 7'd2) begin
      bad++; $display("FAIL stall_resume calc=%b addr=%0d want 1/2", bus_if.eng_calc_en, bus_if.bm_mem_rd_addr);
    end
    cyc = 0;
    while (!seq_done && cyc < 100) begin @(negedge clk); cyc++; end
    #1;
    seq_ok = (addr_q.size() == 4);
    for (int i = 0; i < 4 && seq_ok; i++) if (addr_q[i] != i) seq_ok = 1'b0;
    total++;
    if (!seq_ok || n_wr != 4 || n_done != 1) begin
      bad++; $display("FAIL stall_totals addrs=%p wr=%0d done=%0d want 0..3/4/1", addr_q, n_wr, n_done);
    end
  endtask

  task automatic test_clamp();
    bit to;
    run_job(1, 2, 200, to);
    total++;
    if (to || n_calc != 4 || addr_q.size() != 4 || addr_q[1] != 1 || addr_q[3] != 1) begin
      bad++; $display("FAIL clamp_min calc=%0d addrs=%p want 4 rows 0,1,0,1", n_calc, addr_q);
    end
    run_job(200, 1, 400, to);
    total++;
    if (to || n_calc != 128 || n_wr != 128 || addr_q.size() != 128 || addr_q[127] != 127) begin
      bad++; $display("FAIL clamp_max calc=%0d wr=%0d timeout=%0d want 128/128/0", n_calc, n_wr, to);
    end
    run_job(128, 1, 400, to);
    total++;
    if (to || n_calc != 128 || n_done != 1) begin
      bad++; $display("FAIL m_at_max calc=%0d done=%0d want 128/1", n_calc, n_done);
    end
  endtask

  task automatic test_zero_lines();
    clr_mon();
    @(negedge clk);
    MReg = 8'd4; line_cnt_reg = 16'd0; cntrl_start = 1'b1;
    @(negedge clk);
    cntrl_start = 1'b0;
    total++;
    if (seq_busy !== 1'b1 || seq_done !== 1'b0) begin
      bad++; $display("FAIL zero_first busy=%b done=%b want 1/0", seq_busy, seq_done);
    end
    @(negedge clk);
    total++;
    if (seq_done !== 1'b1 || seq_busy !== 1'b0) begin
      bad++; $display("FAIL zero_done done=%b busy=%b want 1/0", seq_done, seq_busy);
    end
    @(negedge clk);
    #1;
    total++;
    if (seq_done !== 1'b0 || n_rd != 0 || n_mem != 0 || n_calc != 0 || n_load != 0 || n_done != 1) begin
      bad++; $display("FAIL zero_access done=%b rd=%0d mem=%0d calc=%0d load=%0d pulses=%0d want 0/0/0/0/0/1",
                      seq_done, n_rd, n_mem, n_calc, n_load, n_done);
    end
  endtask

  task automatic test_eng_rstn();
    bit to;
    bit seq_ok;
    clr_mon();
    @(negedge clk);
    MReg = 8'd8; line_cnt_reg = 16'd1; cntrl_start = 1'b1;
    @(negedge clk);
    cntrl_start = 1'b0;
    for (int i = 0; i < 30 && !(bus_if.eng_calc_en && bus_if.bm_mem_rd_addr == 7'd2); i++) @(negedge clk);
    total++;
    if (!(bus_if.eng_calc_en && bus_if.bm_mem_rd_addr == 7'd2)) begin
      bad++; $display("FAIL soft_setup row2 never issued addr=%0d", bus_if.bm_mem_rd_addr);
    end
    eng_rstn = 1'b0; cntrl_start = 1'b1; MReg = 8'd4; line_cnt_reg = 16'd1;
    @(negedge clk);
    total++;
    if (all_outs() !== 14'h0) begin
      bad++; $display("FAIL soft_reset_outs got=%h want=0", all_outs());
    end
    eng_rstn = 1'b1; cntrl_start = 1'b0;
    clr_mon();
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (n_calc != 0 || n_done != 0 || seq_busy !== 1'b0) begin
      bad++; $display("FAIL soft_idle calc=%0d done=%0d busy=%b want 0/0/0", n_calc, n_done, seq_busy);
    end
    run_job(4, 1, 100, to);
    seq_ok = (addr_q.size() == 4);
    for (int i = 0; i < 4 && seq_ok; i++) if (addr_q[i] != i) seq_ok = 1'b0;
    total++;
    if (to || !seq_ok || n_done != 1 || n_rd != 1) begin
      bad++; $display("FAIL soft_rerun addrs=%p done=%0d rd=%0d timeout=%0d want 0..3/1/1/0", addr_q, n_done, n_rd, to);
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    int cyc;
    clr_mon();
    @(negedge clk);
    MReg = 8'd2; line_cnt_reg = 16'd3; cntrl_start = 1'b1;
    @(negedge clk);
    cntrl_start = 1'b0;
    repeat (3) @(negedge clk);
    MReg = 8'd6; line_cnt_reg = 16'd5; cntrl_start = 1'b1;
    @(negedge clk);
    cntrl_start = 1'b0;
    cyc = 0;
    while (!seq_done && cyc < 200) begin @(negedge clk); cyc++; end
    to = !seq_done;
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (to || n_calc != 6 || n_rd != 3 || n_done != 1) begin
      bad++; $display("FAIL ignore_start calc=%0d rd=%0d done=%0d timeout=%0d want 6/3/1/0", n_calc, n_rd, n_done, to);
    end
    run_job(3, 1, 100, to);
    total++;
    if (to || n_calc != 3 || n_done != 1) begin
      bad++; $display("FAIL back_to_back calc=%0d done=%0d want 3/1", n_calc, n_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fifo_empty();
    test_stall();
    test_clamp();
    test_zero_lines();
    test_eng_rstn();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encode_seq_cntl.md
ENCODE_SEQ_CNTL -- requirements
Module: encode_seq_cntl

Interface
REQ-001 SHALL have parameter M_MAX, default 128: maximum parity rows per data line.
REQ-002 SHALL have parameter M_MIN, default 2: minimum parity rows per data line.
REQ-003 SHALL have parameter LINE_CNT_W, default 16: width of the job line count.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port eng_rstn, input, 1: synchronous active-low engine soft reset.
REQ-007 SHALL have port cntrl_start, input, 1: one-cycle job start pulse.
REQ-008 SHALL have port MReg, input, M_W: parity row count, sampled at start.
REQ-009 SHALL have port line_cnt_reg, input, LINE_CNT_W: data lines in the job, sampled at start.
REQ-010 SHALL have port inbuf_fifo_empty, input, 1: input FIFO has no line.
REQ-011 SHALL have port outbuf_fifo_afull, input, 1: output FIFO has at most 1 free entry.
REQ-012 SHALL have port inbuf_fifo_rd_rq, output, 1: pop one data line; data valid the following cycle.
REQ-013 SHALL have port bm_mem_rd_en, output, 1: bitmatrix memory row read.
REQ-014 SHALL have port bm_mem_rd_addr, output, ROW_W: bitmatrix row index.
REQ-015 SHALL have port eng_calc_en, output, 1: engine computes one parity row this cycle.
REQ-016 SHALL have port eng_line_load, output, 1: engine latches the new data line.
REQ-017 SHALL have port outbuf_fifo_wr_rq, output, 1: push one parity row.
REQ-018 SHALL have port seq_busy, output, 1: job in progress.
REQ-019 SHALL have port seq_done, output, 1: one-cycle job completion pulse.

Function
REQ-020 SHALL implement an FSM with states IDLE, FETCH, LOAD, CALC and DONE.
REQ-021 SHALL, in IDLE on cntrl_start, latch M_eff and lines_left=line_cnt_reg, then go to FETCH, or to DONE if line_cnt_reg==0.
REQ-022 SHALL clamp M_eff to M_MIN when MReg<M_MIN and to M_MAX when MReg>M_MAX.
REQ-023 SHALL, in FETCH, assert inbuf_fifo_rd_rq for exactly one cycle when inbuf_fifo_empty==0 and go to LOAD; it SHALL hold in FETCH while the FIFO is empty, without requesting.
REQ-024 SHALL, in LOAD, assert eng_line_load for one cycle, clear row=0 and go to CALC.
REQ-025 SHALL, in CALC on each cycle with outbuf_fifo_afull==0, assert bm_mem_rd_en and eng_calc_en with bm_mem_rd_addr=row, then increment row.
REQ-026 SHALL, in CALC while outbuf_fifo_afull==1, deassert bm_mem_rd_en and eng_calc_en and hold row.
REQ-027 SHALL assert outbuf_fifo_wr_rq exactly one cycle after each eng_calc_en (registered copy), including across a stall or a state change.
REQ-028 SHALL, on issue of row==M_eff-1, decrement lines_left; it SHALL then go to DONE if lines_left was 1, else to FETCH.
REQ-029 SHALL issue exactly M_eff eng_calc_en pulses per line and exactly one inbuf_fifo_rd_rq per line.
REQ-030 SHALL, in DONE, wait until outbuf_fifo_wr_rq is low, then assert seq_done for one cycle and return to IDLE.
REQ-031 SHALL assert seq_busy in every state except IDLE.
REQ-032 SHALL ignore cntrl_start outside IDLE.
REQ-033 SHALL use ROW_W=$clog2(M_MAX) for the row counter.
REQ-034 SHALL use M_W=$clog2(M_MAX+1) for MReg, with no overflow at M_MAX.

Reset
REQ-035 SHALL, on rstn low, asynchronously force state IDLE, clear row, lines_left and M_eff, and drive all outputs to 0.
REQ-036 SHALL, on eng_rstn low at a clock edge, apply the same values synchronously, overriding cntrl_start and any in-flight outbuf_fifo_wr_rq.

Structure
REQ-037 SHALL take the state enum and the M_W/ROW_W helper functions from the shared package ec_pkg.
REQ-038 SHALL be a single module with no sub-module; the row and line counters stay inline.

Verification
REQ-039 SHALL cover: M=4, lines=2, FIFO non-empty, afull=0 -> 2 rd_rq, 8 calc_en at addr 0,1,2,3,0,1,2,3, 8 wr_rq, one seq_done.
REQ-040 SHALL cover: inbuf empty for 5 cycles in FETCH -> no rd_rq during those 5 cycles, rd_rq the cycle after empty falls.
REQ-041 SHALL cover: afull high 3 cycles mid-line at row 2 -> addr holds at 2, no calc_en for 3 cycles, total count unchanged.
REQ-042 SHALL cover: MReg=1, then MReg=200 with M_MAX=128 -> 2 and 128 rows per line respectively.
REQ-043 SHALL cover: line_cnt_reg=0 -> seq_done 2 cycles after start with no FIFO or memory access.
REQ-044 SHALL cover: eng_rstn pulsed in CALC at row 3 -> next cycle IDLE with all outputs 0, and a new start runs cleanly.
